// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared integer register-file constants and types for the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       data_t;

  // x1..x31 only; x0 has no storage.
  typedef logic [NREGS-1:1][XLEN-1:0] reg_array_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/reg_file_rport.sv
// ============================================================================
// Module   : reg_file_rport
// Brief    : Combinational register read mux; address x0 always returns zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_rport
  import riscv_pkg::*;
(
  input  reg_array_t regs,
  input  reg_addr_t  addr,
  output data_t      rd
);

  // Decoder starts at x1, so x0 (and anything unmatched) falls through to zero.
  always_comb begin
    rd = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (addr == REG_ADDR_W'(i)) begin
        rd = regs[i];
      end
    end
  end

endmodule : reg_file_rport

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module   : reg_file
// Brief    : 32 x 32-bit RISC-V integer register file, 2 async reads, 1 write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        WE3,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  reg_array_t regs;

  // Async clear has priority, so writes are dropped for as long as reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (WE3 && (A3 != REG_ZERO)) begin
      for (int i = 1; i < NREGS; i++) begin
        if (A3 == REG_ADDR_W'(i)) begin
          regs[i] <= WD3;
        end
      end
    end
  end

  reg_file_rport u_rport1 (
    .regs (regs),
    .addr (A1),
    .rd   (RD1)
  );

  reg_file_rport u_rport2 (
    .regs (regs),
    .addr (A2),
    .rd   (RD2)
  );

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module   : tb_reg_file
// Brief    : Scoreboard bench for reg_file: reset, writes, x0, RDW, async reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        WE3 = 1'b0;
  logic [4:0]  A3 = '0;
  logic [31:0] WD3 = '0;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [31:0] RD1;
  logic [31:0] RD2;

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .WE3   (WE3),
    .A3    (A3),
    .WD3   (WD3),
    .A1    (A1),
    .A2    (A2),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive read addresses, queue the expected pair, then compare once settled.
  task automatic read(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    A1 = a1;
    A2 = a2;
    e.tag = tag; e.exp1 = e1; e.exp2 = e2;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_rd1"}, RD1, e.exp1);
      check({e.tag, "_rd2"}, RD2, e.exp2);
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    WE3 = 1'b1; A3 = a; WD3 = d;
    @(posedge clk);
    #1;
    WE3 = 1'b0;
    if (reset && a != 5'd0) model[a] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset held: reads are zero, write attempted across an edge is ignored.
    @(negedge clk);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h5555_5555;
    @(posedge clk); #1;
    WE3 = 1'b0;
    read("rst_hold", 5'd3, 5'd31, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    read("post_rst", 5'd1, 5'd31, 32'h0, 32'h0);

    write(5'd1, 32'h1);
    write(5'd2, 32'h2);
    read("wr_basic", 5'd2, 5'd1, model[2], model[1]);
    read("same_reg", 5'd2, 5'd2, 32'h2, 32'h2);

    write(5'd0, 32'hDEAD_BEEF);
    read("x0_write", 5'd0, 5'd0, 32'h0, 32'h0);

    write(5'd7, 32'h12);
    @(negedge clk);
    WE3 = 1'b0; A3 = 5'd7; WD3 = 32'hFFFF;
    @(posedge clk); #1;
    read("we_off", 5'd0, 5'd7, 32'h0, 32'h12);

    // Read-during-write: old value before the edge, new value after.
    write(5'd5, 32'hA);
    @(negedge clk);
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hB;
    read("rdw_before", 5'd5, 5'd5, 32'hA, 32'hA);
    @(posedge clk); #1;
    WE3 = 1'b0;
    model[5] = 32'hB;
    read("rdw_after", 5'd5, 5'd1, 32'hB, 32'h1);

    // Fill x1..x31 with non-zero patterns, spot-check extremes.
    for (int i = 1; i < 32; i++) write(5'(i), $urandom() | 32'h1);
    read("fill_lo", 5'd1, 5'd31, model[1], model[31]);
    read("fill_mid", 5'd16, 5'd15, model[16], model[15]);

    // Async reset between edges: zero without any clock edge.
    @(negedge clk); #1;
    reset = 1'b0;
    read("async_rst", 5'd31, 5'd1, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 1; i < 32; i += 6) read("rst_all", 5'(i), 5'(32 - i), 32'h0, 32'h0);

    // Release mid-cycle; the next edge with reset high takes the write.
    @(negedge clk); #2;
    reset = 1'b1;
    write(5'd9, 32'hCAFE_F00D);
    read("post_release", 5'd9, 5'd8, 32'hCAFE_F00D, 32'h0);

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file

`default_nettype wire
